aep_mem_arb: RTL and testbench

Two-requester round-robin arbiter and bounds-checking controller for a small register-file memory (DEPTH entries × DW bits). It accepts at most one read or write per cycle and returns a registered response one cycle after acceptance. Out-of-range addresses are rejected without touching storage, and they are counted for assertion-lab bounds checking. It sits between two client ports and the `aep` memory array and owns that array's storage and reset.

---
 rtl/aep_mem_arb_if.sv | 41 ++++
 rtl/aep_mem_arb.sv | 115 +++++++++++
 tb/tb_aep_mem_arb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aep_mem_arb_if.sv
// aep_mem_arb_if: the two client request ports and the shared response bus
// of the aep memory arbiter.
//   req0_* / req1_* : valid, we, addr, wdata from each client; ready back
//   rsp0_valid / rsp1_valid : one-cycle response pulse for the accepted client
//   rsp_err / rsp_rdata     : shared response payload, valid with the pulse
// master = client side (drives requests), slave = arbiter side.
interface aep_mem_arb_if #(
  parameter int DW = 2,
  parameter int AW = 3
);
  logic          req0_valid;
  logic          req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_ready;

  logic          req1_valid;
  logic          req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_ready;

  logic          rsp0_valid;
  logic          rsp1_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/aep_mem_arb.sv
// aep_mem_arb: two-requester round-robin arbiter in front of a DEPTH x DW
// register-file memory with bounds checking and an error counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request/response interface (slave side)
//   clr_err    : synchronous clear of err_cnt / err_sticky
//   err_cnt    : saturating count of out-of-range accesses
//   err_sticky : set by any out-of-range access until cleared
module aep_mem_arb #(
  parameter int DW    = 2,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  aep_mem_arb_if.slave bus,
  input  logic         clr_err,
  output logic [7:0]   err_cnt,
  output logic         err_sticky
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          last_gnt_q, last_gnt_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          err_sticky_q, err_sticky_d;

  logic          gnt0, gnt1, accept;
  logic          sel_we, in_range;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata, rd_word;
  logic [7:0]    err_base;

  // last_gnt_q = 1 means req1 was accepted most recently, so req0 wins a tie.
  always_comb begin
    gnt0 = bus.req0_valid & (~bus.req1_valid | last_gnt_q);
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_gnt_q);
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Address decode compares the whole zero-extended address, and the array
  // is selected by exact match, so out-of-range addresses never alias.
  always_comb begin
    accept    = gnt0 | gnt1;
    sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
    sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
    in_range  = 32'(sel_addr) < 32'(DEPTH);
    rd_word   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(sel_addr) == 32'(i)) rd_word = mem_q[i];
    end
  end

  always_comb begin
    mem_d        = mem_q;
    last_gnt_d   = last_gnt_q;
    rsp0_valid_d = gnt0;
    rsp1_valid_d = gnt1;
    rsp_err_d    = accept & ~in_range;
    rsp_rdata_d  = (accept & ~sel_we & in_range) ? rd_word : '0;
    // Clear applies first so a simultaneous error still counts as one.
    err_base     = clr_err ? 8'd0 : err_cnt_q;
    err_cnt_d    = err_base;
    err_sticky_d = clr_err ? 1'b0 : err_sticky_q;
    if (accept) begin
      last_gnt_d = gnt1;
      if (in_range) begin
        if (sel_we) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (32'(sel_addr) == 32'(i)) mem_d[i] = sel_wdata;
          end
        end
      end else begin
        err_sticky_d = 1'b1;
        if (err_base != 8'hFF) err_cnt_d = err_base + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_gnt_q   <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      err_cnt_q    <= 8'd0;
      err_sticky_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      last_gnt_q   <= last_gnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign err_cnt        = err_cnt_q;
  assign err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_aep_mem_arb.sv
// tb_aep_mem_arb: self-checking bench for aep_mem_arb. A behavioural model
// (plain int array memory, last-winner integer, error counter) predicts
// grants and responses for directed and randomized traffic.
module tb_aep_mem_arb;
  localparam int DW    = 2;
  localparam int AW    = 3;
  localparam int DEPTH = 2;

  typedef struct {
    bit            v;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr_err = 1'b0;
  logic [7:0] err_cnt;
  logic       err_sticky;

  aep_mem_arb_if #(.DW(DW), .AW(AW)) bus ();

  aep_mem_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_err    (clr_err),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference state
  int memModel [DEPTH];
  int lastModel;
  int cntModel;
  int stickyModel;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) memModel[i] = 0;
    lastModel   = 1;
    cntModel    = 0;
    stickyModel = 0;
  endtask

  // One clock cycle: drive inputs, check grants, advance the model, then
  // check the registered response after the acceptance edge.
  task automatic applyStimulus(input req_t r0, input req_t r1, input bit c,
                               output int obsGnt, output int expGnt);
    int g, addr, wd, expData, expErr;
    bit we;
    bus.req0_valid = r0.v; bus.req0_we = r0.we; bus.req0_addr = r0.a; bus.req0_wdata = r0.d;
    bus.req1_valid = r1.v; bus.req1_we = r1.we; bus.req1_addr = r1.a; bus.req1_wdata = r1.d;
    clr_err = c;
    #1;
    if (r0.v && r1.v) g = (lastModel == 1) ? 0 : 1;
    else if (r0.v)    g = 0;
    else if (r1.v)    g = 1;
    else              g = -1;
    obsGnt = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
    expGnt = g;
    checkOutput("req0_ready", int'(bus.req0_ready), int'(g == 0));
    checkOutput("req1_ready", int'(bus.req1_ready), int'(g == 1));
    expData = 0;
    expErr  = 0;
    if (c) begin
      cntModel    = 0;
      stickyModel = 0;
    end
    if (g >= 0) begin
      addr = (g == 0) ? int'(r0.a) : int'(r1.a);
      wd   = (g == 0) ? int'(r0.d) : int'(r1.d);
      we   = (g == 0) ? r0.we : r1.we;
      if (addr >= DEPTH) begin
        expErr      = 1;
        stickyModel = 1;
        if (cntModel < 255) cntModel++;
      end else if (we) begin
        memModel[addr] = wd;
      end else begin
        expData = memModel[addr];
      end
      lastModel = g;
    end
    @(posedge clk);
    #1;
    checkOutput("rsp0_valid", int'(bus.rsp0_valid), int'(g == 0));
    checkOutput("rsp1_valid", int'(bus.rsp1_valid), int'(g == 1));
    checkOutput("rsp_both", int'(bus.rsp0_valid & bus.rsp1_valid), 0);
    checkOutput("rsp_err", int'(bus.rsp_err), expErr);
    checkOutput("rsp_rdata", int'(bus.rsp_rdata), expData);
    checkOutput("err_cnt", int'(err_cnt), cntModel);
    checkOutput("err_sticky", int'(err_sticky), stickyModel);
  endtask

  function automatic req_t mk(input bit v, input bit we, input int a, input int d);
    req_t r;
    r.v  = v;
    r.we = we;
    r.a  = AW'(a);
    r.d  = DW'(d);
    return r;
  endfunction

  // A request that was not accepted must stay up with the same payload.
  req_t prev0, prev1;
  always @(posedge clk) begin
    if (!rst_n) begin
      prev0.v <= 1'b0;
      prev1.v <= 1'b0;
    end else begin
      if (prev0.v && !(bus.req0_valid && bus.req0_we == prev0.we &&
                       bus.req0_addr == prev0.a && bus.req0_wdata == prev0.d))
        $error("[TB] requester 0 dropped or changed a pending request");
      if (prev1.v && !(bus.req1_valid && bus.req1_we == prev1.we &&
                       bus.req1_addr == prev1.a && bus.req1_wdata == prev1.d))
        $error("[TB] requester 1 dropped or changed a pending request");
      prev0.v  <= bus.req0_valid && !bus.req0_ready;
      prev0.we <= bus.req0_we; prev0.a <= bus.req0_addr; prev0.d <= bus.req0_wdata;
      prev1.v  <= bus.req1_valid && !bus.req1_ready;
      prev1.we <= bus.req1_we; prev1.a <= bus.req1_addr; prev1.d <= bus.req1_wdata;
    end
  end

  initial begin
    int og, eg;
    req_t idle, p0, p1;
    idle = mk(0, 0, 0, 0);
    bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
    resetModel();

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_rsp0_valid", int'(bus.rsp0_valid), 0);
    checkOutput("reset_rsp1_valid", int'(bus.rsp1_valid), 0);
    checkOutput("reset_rsp_err", int'(bus.rsp_err), 0);
    checkOutput("reset_rsp_rdata", int'(bus.rsp_rdata), 0);
    checkOutput("reset_err_cnt", int'(err_cnt), 0);
    checkOutput("reset_err_sticky", int'(err_sticky), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset then read
    applyStimulus(mk(1, 0, 0, 0), idle, 0, og, eg);
    applyStimulus(mk(1, 0, 1, 0), idle, 0, og, eg);

    // Write then read back from req1
    applyStimulus(idle, mk(1, 1, 1, 3), 0, og, eg);
    applyStimulus(idle, mk(1, 0, 1, 0), 0, og, eg);
    checkOutput("readback_data", int'(bus.rsp_rdata), 3);
    applyStimulus(idle, mk(1, 0, 0, 0), 0, og, eg);

    // Out of range write and read from req0
    applyStimulus(mk(1, 1, 5, 2), idle, 0, og, eg);
    applyStimulus(mk(1, 0, 7, 0), idle, 0, og, eg);
    checkOutput("oor_err_cnt", int'(err_cnt), 2);
    checkOutput("oor_sticky", int'(err_sticky), 1);
    applyStimulus(mk(1, 0, 1, 0), idle, 0, og, eg);
    checkOutput("no_alias_mem1", int'(bus.rsp_rdata), 3);
    applyStimulus(mk(1, 0, 0, 0), idle, 0, og, eg);

    // Counter saturation and clear
    for (int i = 0; i < 256; i++) applyStimulus(idle, mk(1, 0, 6, 0), 0, og, eg);
    checkOutput("sat_err_cnt", int'(err_cnt), 255);
    applyStimulus(mk(1, 0, 4, 0), idle, 1, og, eg);
    checkOutput("clr_with_err_cnt", int'(err_cnt), 1);
    applyStimulus(idle, idle, 1, og, eg);
    checkOutput("clr_alone_cnt", int'(err_cnt), 0);
    checkOutput("clr_alone_sticky", int'(err_sticky), 0);

    // Randomized traffic with requests held until accepted
    p0 = idle;
    p1 = idle;
    for (int i = 0; i < 400; i++) begin
      if (!p0.v && $urandom_range(0, 2) != 0)
        p0 = mk(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3));
      if (!p1.v && $urandom_range(0, 2) != 0)
        p1 = mk(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3));
      applyStimulus(p0, p1, ($urandom_range(0, 19) == 0), og, eg);
      if (eg == 0) p0 = idle;
      if (eg == 1) p1 = idle;
    end

    // Leave some state behind, then reset the cycle after an acceptance
    applyStimulus(mk(1, 1, 1, 2), idle, 0, og, eg);
    applyStimulus(mk(1, 0, 3, 0), idle, 0, og, eg);
    bus.req0_valid = 1; bus.req0_we = 1; bus.req0_addr = 3'd0; bus.req0_wdata = 2'd3;
    clr_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req0_valid = 0;
    #1;
    resetModel();
    checkOutput("midrst_rsp0_valid", int'(bus.rsp0_valid), 0);
    checkOutput("midrst_rsp_err", int'(bus.rsp_err), 0);
    checkOutput("midrst_rsp_rdata", int'(bus.rsp_rdata), 0);
    checkOutput("midrst_err_cnt", int'(err_cnt), 0);
    checkOutput("midrst_err_sticky", int'(err_sticky), 0);
    bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 3'd0;
    #1;
    checkOutput("ready_in_reset", int'(bus.req1_ready), 1);
    @(posedge clk); @(negedge clk);
    bus.req1_valid = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_rsp1_valid", int'(bus.rsp1_valid), 0);
    applyStimulus(idle, idle, 0, og, eg);

    // Sustained contention from reset: grants 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mk(1, 0, 0, 0), mk(1, 0, 0, 0), 0, og, eg);
      checkOutput("contention_order", og, i % 2);
    end

    // Memory back at reset values
    applyStimulus(mk(1, 0, 0, 0), idle, 0, og, eg);
    checkOutput("post_rst_mem0", int'(bus.rsp_rdata), 0);
    applyStimulus(mk(1, 0, 1, 0), idle, 0, og, eg);
    checkOutput("post_rst_mem1", int'(bus.rsp_rdata), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
